// File: rtl/fsm_driver.sv
// Initiator-side sequencer for the 2-bit start/init/done/ack control FSM:
// latches a job, burns its work cycles, then walks the control FSM through one handshake.
module fsm_driver #(
    parameter int LEN_W        = 8,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             req_ready_o,
    input  logic [1:0]       ctrl_state_i,
    input  logic             ack_i,
    output logic             init_o,
    output logic             start_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             job_done_o,
    output logic             err_o,
    output logic [7:0]       err_count_o
);

    localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WORK,
        SYNC,
        ISSUE,
        DONE,
        RETIRE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              err_set;
    logic              retire_ok;
    logic              ready_q, busy_q, start_q, done_q, job_done_q, err_q;
    logic [7:0]        err_count_q;

    // Every mismatch path falls back to SYNC with a fresh timeout window;
    // the latched job stays, so WORK is never repeated on a retry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_set   = 1'b0;
        retire_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cnt_d   = (req_len_i == '0) ? LEN_W'(1) : req_len_i;
                    state_d = WORK;
                end
            end
            WORK: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = SYNC;
                    tmo_d   = '0;
                end
            end
            SYNC: begin
                if (ack_i) begin
                    state_d = ISSUE;
                end else if (tmo_q == TO_W'(SYNC_TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    err_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            ISSUE: begin
                if (ctrl_state_i == 2'b00) begin
                    state_d = DONE;
                end else begin
                    err_set = 1'b1;
                    state_d = SYNC;
                    tmo_d   = '0;
                end
            end
            DONE: begin
                if (ctrl_state_i == 2'b01) begin
                    state_d = RETIRE;
                end else begin
                    err_set = 1'b1;
                    state_d = SYNC;
                    tmo_d   = '0;
                end
            end
            RETIRE: begin
                if (ctrl_state_i == 2'b10) begin
                    retire_ok = 1'b1;
                    state_d   = IDLE;
                end else begin
                    err_set = 1'b1;
                    state_d = SYNC;
                    tmo_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs are decoded from the next state so they appear registered
    // in the same cycle as the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            ready_q    <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            start_q    <= (state_d == ISSUE);
            done_q     <= (state_d == DONE);
            job_done_q <= retire_ok;
            err_q      <= err_set;
            if (err_set && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign init_o      = (state_q == SYNC) && ack_i;
    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign start_o     = start_q;
    assign done_o      = done_q;
    assign job_done_o  = job_done_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_fsm_driver.sv
// Self-checking bench for fsm_driver: behavioural control-FSM model, cycle-stamped
// scoreboard of expected job_done cycles, table of nominal jobs plus corner sequences.
module tb_fsm_driver;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic [1:0]       ctrl_state;
    logic             ack;
    logic             init_s, start_s, done_s, busy_s, job_done_s, err_s;
    logic [7:0]       err_count;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    logic [1:0] modelQ = 2'b11;
    int         ovStart = 0, ovEnd = 0;
    logic [1:0] ovVal = 2'b11;

    int sbQ[$];
    int initCyc, startCyc, doneCyc;
    int errPulses  = 0;
    int lastErrCyc = -1;

    fsm_driver #(.LEN_W(LEN_W), .SYNC_TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_len_i    (req_len),
        .req_ready_o  (req_ready),
        .ctrl_state_i (ctrl_state),
        .ack_i        (ack),
        .init_o       (init_s),
        .start_o      (start_s),
        .done_o       (done_s),
        .busy_o       (busy_s),
        .job_done_o   (job_done_s),
        .err_o        (err_s),
        .err_count_o  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Control FSM: 11 parked (ack), init -> 00, 00 -start-> 01, 01 -done-> 10, 10 -> 00;
    // a missing start/done drops it back to the parked state.
    always @(posedge clk) begin
        if (init_s) modelQ <= 2'b00;
        else begin
            case (modelQ)
                2'b00:   modelQ <= start_s ? 2'b01 : 2'b11;
                2'b01:   modelQ <= done_s ? 2'b10 : 2'b11;
                2'b10:   modelQ <= 2'b00;
                default: modelQ <= 2'b11;
            endcase
        end
    end

    assign ctrl_state = (cyc >= ovStart && cyc < ovEnd) ? ovVal : modelQ;
    assign ack        = (ctrl_state == 2'b11);

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("mutex_init_start_done", (int'(init_s) + int'(start_s) + int'(done_s)) > 1, 0);
            if (init_s && initCyc < 0) initCyc = cyc;
            if (start_s && startCyc < 0) startCyc = cyc;
            if (done_s && doneCyc < 0) doneCyc = cyc;
            if (err_s) begin
                errPulses++;
                lastErrCyc = cyc;
            end
            if (job_done_s) begin
                if (sbQ.size() == 0) checkOutput("unexpected_job_done", 1, 0);
                else checkOutput("job_done_cycle", cyc, sbQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int len, input int jdOff, output int a);
        @(negedge clk);
        checkOutput("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        a         = cyc;
        initCyc   = -1;
        startCyc  = -1;
        doneCyc   = -1;
        sbQ.push_back(a + jdOff);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            checkOutput("job_done_timeout_pending", sbQ.size(), 0);
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
    endtask

    typedef struct {
        int len;
        int initOff;
        int startOff;
        int doneOff;
        int jdOff;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int a, a2, s, e0;

        rst = 1'b1;
        req_valid = 1'b0;
        req_len = '0;
        #1;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_busy", busy_s, 0);
        checkOutput("rst_init", init_s, 0);
        checkOutput("rst_start", start_s, 0);
        checkOutput("rst_done", done_s, 0);
        checkOutput("rst_job_done", job_done_s, 0);
        checkOutput("rst_err", err_s, 0);
        checkOutput("rst_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Offsets from the accept cycle for init, start, done and job_done.
        vecs[0] = '{3, 4, 5, 6, 8};
        vecs[1] = '{0, 2, 3, 4, 6};
        vecs[2] = '{1, 2, 3, 4, 6};
        vecs[3] = '{5, 6, 7, 8, 10};
        vecs[4] = '{2, 3, 4, 5, 7};
        vecs[5] = '{255, 256, 257, 258, 260};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].len, vecs[i].jdOff, a);
            @(negedge clk);
            req_valid = 1'b0;
            checkOutput("busy_in_work", busy_s, 1);
            checkOutput("req_ready_in_work", req_ready, 0);
            waitIdle(400);
            checkOutput("init_offset", initCyc - a, vecs[i].initOff);
            checkOutput("start_offset", startCyc - a, vecs[i].startOff);
            checkOutput("done_offset", doneCyc - a, vecs[i].doneOff);
            checkOutput("nominal_err_count", err_count, 0);
            checkOutput("idle_busy", busy_s, 0);
        end

        // Back-to-back: request held high is taken again in the job_done cycle.
        applyStimulus(2, 7, a);
        sbQ.push_back(a + 14);
        repeat (8) @(negedge clk);
        req_valid = 1'b0;
        waitIdle(100);

        // Ack withheld for 70 SYNC cycles: one timeout error at SYNC entry + 64.
        e0 = errPulses;
        applyStimulus(4, 79, a);
        s = a + 5;
        ovStart = s;
        ovEnd = s + 70;
        ovVal = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        waitIdle(200);
        checkOutput("timeout_err_cycle", lastErrCyc, s + 64);
        checkOutput("timeout_err_pulses", errPulses - e0, 1);
        checkOutput("timeout_err_count", err_count, 1);

        // Wrong ctrl_state during DONE: one error, retry through SYNC, one job_done.
        resetDut();
        e0 = errPulses;
        applyStimulus(2, 12, a);
        ovStart = a + 5;
        ovEnd = a + 6;
        ovVal = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        waitIdle(100);
        checkOutput("done_err_cycle", lastErrCyc, a + 6);
        checkOutput("done_err_pulses", errPulses - e0, 1);
        checkOutput("done_err_count", err_count, 1);

        // Asynchronous reset while DONE is driven discards the job.
        e0 = errPulses;
        applyStimulus(2, 7, a);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("in_done_before_rst", done_s, 1);
        rst = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("async_rst_done", done_s, 0);
        checkOutput("async_rst_busy", busy_s, 0);
        checkOutput("async_rst_req_ready", req_ready, 1);
        checkOutput("async_rst_err_count", err_count, 0);
        checkOutput("async_rst_job_done", job_done_s, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1;
        req_len = 8'd2;
        a2 = cyc;
        sbQ.push_back(a2 + 7);
        @(negedge clk);
        req_valid = 1'b0;
        waitIdle(100);
        checkOutput("after_rst_err_pulses", errPulses - e0, 0);
        checkOutput("after_rst_err_count", err_count, 0);

        // 300 forced ISSUE mismatches: err_count saturates at FF without wrapping.
        e0 = errPulses;
        applyStimulus(1, 606, a);
        ovStart = a + 3;
        ovEnd = a + 603;
        ovVal = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        waitIdle(900);
        checkOutput("sat_err_pulses", errPulses - e0, 300);
        checkOutput("sat_err_count", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
